// File: rtl/tile_size_scheduler.sv
// ---------------------------------------------------------------------------
// tile_size_scheduler
//
// Purpose:
//   Feeds 8x8 RGB tiles, one at a time, through the tile compressed-size core.
//   It also turns each core result into per-tile packing information for the
//   stream packer.
//
//   For every accepted tile descriptor the scheduler:
//     1. Captures the flag vectors into a hold register. The core sees them
//        unchanged for its whole computation.
//     2. Issues a single-cycle launch pulse to the core.
//     3. Waits a bounded number of cycles for the core result strobe.
//     4. Applies the raw-fallback rule. A result larger than MAX_COMP_BYTES,
//        or a missing result, stores the tile raw (RAW_BYTES).
//     5. Presents byte size, mode, frame byte offset and tile index on a
//        valid/ready output and holds them until the packer accepts.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   s_valid / s_ready      tile descriptor handshake (s_ready is registered)
//   s_flag_data            per-pixel 3-bit flags            (3*T*T bits)
//   s_judge                per-row mode codes               (2*T bits)
//   s_diff_flag_data       per-row diff flags               (3*T bits)
//   s_same_flag_data       per-row same flags               (3*T bits)
//   core_i_valid           one-cycle launch pulse to the size core
//   core_*                 held copies of the s_* vectors for the core
//   core_o_valid           size core result strobe
//   core_byte_size         size core result (7 bits)
//   m_valid / m_ready      result handshake towards the packer
//   m_byte_size            bytes this tile occupies in the stream
//   m_raw                  1 = tile stored raw
//   m_err                  1 = core result never arrived (timeout)
//   m_offset               frame byte offset where this tile starts
//   m_tile_idx             tile index within the frame
//   m_last                 this is the last tile of the frame
// ---------------------------------------------------------------------------
module tile_size_scheduler #(
    parameter int TILE_SIZE       = 8,
    parameter int MAX_COMP_BYTES  = 96,
    parameter int TILES_PER_FRAME = 16,
    parameter int TIMEOUT         = 24,
    parameter int OFF_W           = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,

    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [3*TILE_SIZE*TILE_SIZE-1:0]   s_flag_data,
    input  logic [2*TILE_SIZE-1:0]             s_judge,
    input  logic [3*TILE_SIZE-1:0]             s_diff_flag_data,
    input  logic [3*TILE_SIZE-1:0]             s_same_flag_data,

    output logic                               core_i_valid,
    output logic [3*TILE_SIZE*TILE_SIZE-1:0]   core_flag_data,
    output logic [2*TILE_SIZE-1:0]             core_judge,
    output logic [3*TILE_SIZE-1:0]             core_diff_flag_data,
    output logic [3*TILE_SIZE-1:0]             core_same_flag_data,
    input  logic                               core_o_valid,
    input  logic [6:0]                         core_byte_size,

    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [7:0]                         m_byte_size,
    output logic                               m_raw,
    output logic                               m_err,
    output logic [OFF_W-1:0]                   m_offset,
    output logic [3:0]                         m_tile_idx,
    output logic                               m_last
);

    // A raw tile holds every pixel as three bytes.
    localparam int RAW_BYTES = 3 * TILE_SIZE * TILE_SIZE;

    // The wait counter only has to reach TIMEOUT-1. The last WAIT cycle is
    // the one in which the counter holds that value.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [7:0]       RAW_SIZE     = 8'(RAW_BYTES);
    localparam logic [6:0]       MAX_COMP     = 7'(MAX_COMP_BYTES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       LAST_IDX     = 4'(TILES_PER_FRAME - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [CNT_W-1:0] wait_cnt;

    logic             accept;
    logic             result_load;
    logic             timeout_hit;
    logic             handshake;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and decoded strobes.
    // While in WAIT, a core strobe takes priority over the timeout. A result
    // that arrives in the final permitted cycle is therefore still used.
    // A strobe seen in any other state is simply not looked at.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        core_i_valid = 1'b0;
        m_valid      = 1'b0;
        accept       = 1'b0;
        result_load  = 1'b0;
        timeout_hit  = 1'b0;
        handshake    = 1'b0;

        case (state)
            IDLE: begin
                if (s_valid && s_ready) begin
                    accept     = 1'b1;
                    state_next = LAUNCH;
                end
            end

            LAUNCH: begin
                core_i_valid = 1'b1;
                state_next   = WAIT;
            end

            WAIT: begin
                if (core_o_valid) begin
                    result_load = 1'b1;
                    state_next  = OUT;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = OUT;
                end
            end

            OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // s_ready is registered from the next state.
    // It rises on the edge that enters IDLE, which includes the first edge
    // after reset release. It falls on the accepting edge. Back-to-back tiles
    // can therefore be accepted one cycle after the output handshake.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready <= 1'b0;
        end else begin
            s_ready <= (state_next == IDLE);
        end
    end

    // -----------------------------------------------------------------------
    // Tile hold register.
    // It loads only on an IDLE accept, so the core inputs stay frozen from
    // the launch pulse until the next tile is taken.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_flag_data      <= '0;
            core_judge          <= '0;
            core_diff_flag_data <= '0;
            core_same_flag_data <= '0;
        end else if (accept) begin
            core_flag_data      <= s_flag_data;
            core_judge          <= s_judge;
            core_diff_flag_data <= s_diff_flag_data;
            core_same_flag_data <= s_same_flag_data;
        end
    end

    // -----------------------------------------------------------------------
    // WAIT cycle counter.
    // It is cleared during LAUNCH, so it reads 0 in the first WAIT cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == LAUNCH) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Result register with the raw-fallback rule.
    // A compressed tile may not exceed MAX_COMP_BYTES; anything larger is
    // stored raw. A timeout is also reported raw, with m_err raised. Every
    // new result overwrites m_err, so a previous timeout does not linger.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_byte_size <= '0;
            m_raw       <= 1'b0;
            m_err       <= 1'b0;
        end else if (result_load) begin
            m_err <= 1'b0;
            if (core_byte_size <= MAX_COMP) begin
                m_byte_size <= {1'b0, core_byte_size};
                m_raw       <= 1'b0;
            end else begin
                m_byte_size <= RAW_SIZE;
                m_raw       <= 1'b1;
            end
        end else if (timeout_hit) begin
            m_byte_size <= RAW_SIZE;
            m_raw       <= 1'b1;
            m_err       <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Frame position.
    // m_offset and m_tile_idx describe the tile being presented. They
    // advance only once the packer has taken that tile. After the last tile
    // of a frame both restart at 0. Otherwise the offset grows by the
    // presented size and wraps naturally at 2^OFF_W.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_offset   <= '0;
            m_tile_idx <= '0;
        end else if (handshake) begin
            if (m_last) begin
                m_offset   <= '0;
                m_tile_idx <= '0;
            end else begin
                m_offset   <= m_offset + OFF_W'(m_byte_size);
                m_tile_idx <= m_tile_idx + 1'b1;
            end
        end
    end

    assign m_last = (m_tile_idx == LAST_IDX);

endmodule
